parking_occupancy_ctrl: RTL and testbench

//   Multi-class parking occupancy controller: one slot counter per vehicle class (car, bike, ...),

---
 rtl/parking_pkg.sv | 15 +
 rtl/parking_class_counter.sv | 78 +++++++
 rtl/parking_occupancy_ctrl.sv | 47 ++++
 tb/tb_parking_occupancy_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared constants and helpers for the parking occupancy controller.
package parking_pkg;

    localparam int CLS_CAR  = 0;
    localparam int CLS_BIKE = 1;

    localparam int DEFAULT_CAPACITY = 64;
    localparam int DEFAULT_CNT_W    = 8;

    // Bits needed to hold 0..capacity inclusive.
    function automatic int occ_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

endpackage

// File: rtl/parking_class_counter.sv
// One vehicle class: occupancy counter, total-entered counter and the
// registered grant/deny/error pulses for that class's gate requests.
module parking_class_counter
    import parking_pkg::*;
#(
    parameter int      CAPACITY  = DEFAULT_CAPACITY,
    parameter int      CNT_W     = DEFAULT_CNT_W,
    parameter bit      TOTAL_SAT = 1'b1,
    localparam int     OCC_W     = occ_width(CAPACITY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             clr_totals,
    output logic             entry_grant,
    output logic             entry_deny,
    output logic             exit_err,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] total_entered,
    output logic             full,
    output logic             empty
);

    localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

    logic             exit_ok;
    logic             entry_ok;
    logic [OCC_W-1:0] occ_next;
    logic [CNT_W-1:0] total_next;

    always_comb begin
        // NOTE: every variable gets a default at the top so no path can infer a latch.
        exit_ok    = exit_req && (occupancy != '0);
        // A valid exit in the same cycle frees its slot for the entry.
        entry_ok   = entry_req && ((occupancy < CAP_V) || exit_ok);
        occ_next   = occupancy;
        total_next = total_entered;

        if (entry_ok && !exit_ok) begin
            occ_next = occupancy + OCC_W'(1);
        end else if (!entry_ok && exit_ok) begin
            occ_next = occupancy - OCC_W'(1);
        end

        if (clr_totals) begin
            total_next = entry_ok ? CNT_W'(1) : '0;
        end else if (entry_ok) begin
            if (total_entered == '1) begin
                total_next = TOTAL_SAT ? total_entered : '0;
            end else begin
                total_next = total_entered + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            occupancy     <= '0;
            total_entered <= '0;
            entry_grant   <= 1'b0;
            entry_deny    <= 1'b0;
            exit_err      <= 1'b0;
        end else begin
            occupancy     <= occ_next;
            total_entered <= total_next;
            entry_grant   <= entry_ok;
            entry_deny    <= entry_req && !entry_ok;
            exit_err      <= exit_req && !exit_ok;
        end
    end

    // Decoded straight from the occupancy register, so no added latency.
    assign full  = (occupancy == CAP_V);
    assign empty = (occupancy == '0);

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-class parking occupancy controller: one independent counter per
// vehicle class, with per-class outputs packed onto flat buses.
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int  NUM_CLASSES = 2,
    parameter int  CAPACITY    = DEFAULT_CAPACITY,
    parameter int  CNT_W       = DEFAULT_CNT_W,
    parameter bit  TOTAL_SAT   = 1'b1,
    localparam int OCC_W       = occ_width(CAPACITY)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CLASSES-1:0]       entry_req,
    input  logic [NUM_CLASSES-1:0]       exit_req,
    input  logic                         clr_totals,
    output logic [NUM_CLASSES-1:0]       entry_grant,
    output logic [NUM_CLASSES-1:0]       entry_deny,
    output logic [NUM_CLASSES-1:0]       exit_err,
    output logic [NUM_CLASSES*OCC_W-1:0] occupancy,
    output logic [NUM_CLASSES*CNT_W-1:0] total_entered,
    output logic [NUM_CLASSES-1:0]       full,
    output logic [NUM_CLASSES-1:0]       empty
);

    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_class
        parking_class_counter #(
            .CAPACITY  (CAPACITY),
            .CNT_W     (CNT_W),
            .TOTAL_SAT (TOTAL_SAT)
        ) u_counter (
            .clk           (clk),
            .rst_n         (rst_n),
            .entry_req     (entry_req[i]),
            .exit_req      (exit_req[i]),
            .clr_totals    (clr_totals),
            .entry_grant   (entry_grant[i]),
            .entry_deny    (entry_deny[i]),
            .exit_err      (exit_err[i]),
            .occupancy     (occupancy[i*OCC_W +: OCC_W]),
            .total_entered (total_entered[i*CNT_W +: CNT_W]),
            .full          (full[i]),
            .empty         (empty[i])
        );
    end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl: a saturating instance plus a
// wrapping instance driven by the same stimulus.
module tb_parking_occupancy_ctrl;
    import parking_pkg::*;

    localparam int NC    = 2;
    localparam int CAP   = 3;
    localparam int CNT_W = 4;
    localparam int OCC_W = occ_width(CAP);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NC-1:0]          entry_req = '0;
    logic [NC-1:0]          exit_req = '0;
    logic                   clr_totals = 1'b0;

    logic [NC-1:0]          entry_grant, entry_deny, exit_err, full, empty;
    logic [NC*OCC_W-1:0]    occupancy;
    logic [NC*CNT_W-1:0]    total_entered;

    logic [NC-1:0]          w_entry_grant, w_entry_deny, w_exit_err, w_full, w_empty;
    logic [NC*OCC_W-1:0]    w_occupancy;
    logic [NC*CNT_W-1:0]    w_total_entered;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    parking_occupancy_ctrl #(
        .NUM_CLASSES (NC), .CAPACITY (CAP), .CNT_W (CNT_W), .TOTAL_SAT (1'b1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .entry_req (entry_req), .exit_req (exit_req),
        .clr_totals (clr_totals), .entry_grant (entry_grant), .entry_deny (entry_deny),
        .exit_err (exit_err), .occupancy (occupancy), .total_entered (total_entered),
        .full (full), .empty (empty)
    );

    parking_occupancy_ctrl #(
        .NUM_CLASSES (NC), .CAPACITY (CAP), .CNT_W (CNT_W), .TOTAL_SAT (1'b0)
    ) dut_wrap (
        .clk (clk), .rst_n (rst_n), .entry_req (entry_req), .exit_req (exit_req),
        .clr_totals (clr_totals), .entry_grant (w_entry_grant), .entry_deny (w_entry_deny),
        .exit_err (w_exit_err), .occupancy (w_occupancy), .total_entered (w_total_entered),
        .full (w_full), .empty (w_empty)
    );

    function automatic logic [OCC_W-1:0] occ(input int cls);
        return occupancy[cls*OCC_W +: OCC_W];
    endfunction

    function automatic logic [CNT_W-1:0] tot(input int cls);
        return total_entered[cls*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] w_tot(input int cls);
        return w_total_entered[cls*CNT_W +: CNT_W];
    endfunction

    // Present one cycle of requests, then sample just after the edge.
    task automatic do_cycle(input logic [NC-1:0] ent, input logic [NC-1:0] ext, input logic clr);
        entry_req  = ent;
        exit_req   = ext;
        clr_totals = clr;
        @(posedge clk);
        #1;
        entry_req  = '0;
        exit_req   = '0;
        clr_totals = 1'b0;
    endtask

    task automatic apply_reset();
        entry_req  = '0;
        exit_req   = '0;
        clr_totals = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL reset_occ: got %0h expected 0", occupancy); end
        checks++; if (total_entered !== '0) begin failures++; $display("FAIL reset_total: got %0h expected 0", total_entered); end
        checks++; if ({entry_grant, entry_deny, exit_err} !== '0) begin failures++; $display("FAIL reset_pulses: got %0h expected 0", {entry_grant, entry_deny, exit_err}); end
        checks++; if (full !== 2'b00) begin failures++; $display("FAIL reset_full: got %b expected 00", full); end
        checks++; if (empty !== 2'b11) begin failures++; $display("FAIL reset_empty: got %b expected 11", empty); end
        apply_reset();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= CAP; i++) begin
            do_cycle(2'b01, 2'b00, 1'b0);
            checks++; if (entry_grant !== 2'b01) begin failures++; $display("FAIL fill_grant%0d: got %b expected 01", i, entry_grant); end
            checks++; if (occ(CLS_CAR) !== OCC_W'(i)) begin failures++; $display("FAIL fill_occ%0d: got %0d expected %0d", i, occ(CLS_CAR), i); end
        end
        checks++; if (full !== 2'b01) begin failures++; $display("FAIL fill_full: got %b expected 01", full); end
        checks++; if (empty !== 2'b10) begin failures++; $display("FAIL fill_empty: got %b expected 10", empty); end
        checks++; if (tot(CLS_CAR) !== 4'd3) begin failures++; $display("FAIL fill_total: got %0d expected 3", tot(CLS_CAR)); end
        do_cycle(2'b01, 2'b00, 1'b0);
        checks++; if (entry_deny !== 2'b01) begin failures++; $display("FAIL full_deny: got %b expected 01", entry_deny); end
        checks++; if (entry_grant !== 2'b00) begin failures++; $display("FAIL full_no_grant: got %b expected 00", entry_grant); end
        checks++; if (occ(CLS_CAR) !== 2'd3) begin failures++; $display("FAIL full_occ: got %0d expected 3", occ(CLS_CAR)); end
        checks++; if (tot(CLS_CAR) !== 4'd3) begin failures++; $display("FAIL full_total: got %0d expected 3", tot(CLS_CAR)); end
        do_cycle(2'b00, 2'b00, 1'b0);
        checks++; if ({entry_grant, entry_deny, exit_err} !== '0) begin failures++; $display("FAIL idle_pulses: got %0h expected 0", {entry_grant, entry_deny, exit_err}); end
    endtask

    task automatic test_same_cycle_full();
        do_cycle(2'b01, 2'b01, 1'b0);
        checks++; if (entry_grant !== 2'b01) begin failures++; $display("FAIL swap_grant: got %b expected 01", entry_grant); end
        checks++; if (exit_err !== 2'b00) begin failures++; $display("FAIL swap_err: got %b expected 00", exit_err); end
        checks++; if (occ(CLS_CAR) !== 2'd3) begin failures++; $display("FAIL swap_occ: got %0d expected 3", occ(CLS_CAR)); end
        checks++; if (tot(CLS_CAR) !== 4'd4) begin failures++; $display("FAIL swap_total: got %0d expected 4", tot(CLS_CAR)); end
    endtask

    task automatic test_bike_empty();
        do_cycle(2'b10, 2'b10, 1'b0);
        checks++; if (exit_err !== 2'b10) begin failures++; $display("FAIL bike_pair_err: got %b expected 10", exit_err); end
        checks++; if (entry_grant !== 2'b10) begin failures++; $display("FAIL bike_pair_grant: got %b expected 10", entry_grant); end
        checks++; if (occ(CLS_BIKE) !== 2'd1) begin failures++; $display("FAIL bike_pair_occ: got %0d expected 1", occ(CLS_BIKE)); end
        checks++; if (occ(CLS_CAR) !== 2'd3) begin failures++; $display("FAIL bike_car_indep: got %0d expected 3", occ(CLS_CAR)); end
        do_cycle(2'b00, 2'b10, 1'b0);
        checks++; if (exit_err !== 2'b00) begin failures++; $display("FAIL bike_exit_ok_err: got %b expected 00", exit_err); end
        checks++; if (occ(CLS_BIKE) !== 2'd0) begin failures++; $display("FAIL bike_exit_occ: got %0d expected 0", occ(CLS_BIKE)); end
        do_cycle(2'b00, 2'b10, 1'b0);
        checks++; if (exit_err !== 2'b10) begin failures++; $display("FAIL bike_lone_err: got %b expected 10", exit_err); end
        checks++; if (occ(CLS_BIKE) !== 2'd0) begin failures++; $display("FAIL bike_lone_occ: got %0d expected 0", occ(CLS_BIKE)); end
        checks++; if (empty !== 2'b10) begin failures++; $display("FAIL bike_lone_empty: got %b expected 10", empty); end
    endtask

    task automatic test_total_sat();
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            do_cycle(2'b01, 2'b00, 1'b0);
            do_cycle(2'b00, 2'b01, 1'b0);
            if (i == 15) begin
                checks++; if (w_tot(CLS_CAR) !== 4'd15) begin failures++; $display("FAIL wrap_at15: got %0d expected 15", w_tot(CLS_CAR)); end
            end
            if (i == 16) begin
                checks++; if (w_tot(CLS_CAR) !== 4'd0) begin failures++; $display("FAIL wrap_to0: got %0d expected 0", w_tot(CLS_CAR)); end
                checks++; if (tot(CLS_CAR) !== 4'd15) begin failures++; $display("FAIL sat_at16: got %0d expected 15", tot(CLS_CAR)); end
            end
        end
        checks++; if (tot(CLS_CAR) !== 4'd15) begin failures++; $display("FAIL sat_final: got %0d expected 15", tot(CLS_CAR)); end
        checks++; if (w_tot(CLS_CAR) !== 4'd4) begin failures++; $display("FAIL wrap_final: got %0d expected 4", w_tot(CLS_CAR)); end
        checks++; if (occ(CLS_CAR) !== 2'd0) begin failures++; $display("FAIL pairs_occ: got %0d expected 0", occ(CLS_CAR)); end
    endtask

    task automatic test_clr_totals();
        do_cycle(2'b01, 2'b00, 1'b1);
        checks++; if (tot(CLS_CAR) !== 4'd1) begin failures++; $display("FAIL clr_grant_total: got %0d expected 1", tot(CLS_CAR)); end
        checks++; if (w_tot(CLS_CAR) !== 4'd1) begin failures++; $display("FAIL clr_grant_wtotal: got %0d expected 1", w_tot(CLS_CAR)); end
        checks++; if (occ(CLS_CAR) !== 2'd1) begin failures++; $display("FAIL clr_grant_occ: got %0d expected 1", occ(CLS_CAR)); end
        do_cycle(2'b00, 2'b00, 1'b1);
        checks++; if (tot(CLS_CAR) !== 4'd0) begin failures++; $display("FAIL clr_idle_total: got %0d expected 0", tot(CLS_CAR)); end
        checks++; if (occ(CLS_CAR) !== 2'd1) begin failures++; $display("FAIL clr_idle_occ: got %0d expected 1", occ(CLS_CAR)); end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        do_cycle(2'b01, 2'b00, 1'b0);
        do_cycle(2'b01, 2'b00, 1'b0);
        checks++; if (occ(CLS_CAR) !== 2'd2) begin failures++; $display("FAIL midop_pre_occ: got %0d expected 2", occ(CLS_CAR)); end
        entry_req = 2'b01;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL midop_occ: got %0h expected 0", occupancy); end
        checks++; if (total_entered !== '0) begin failures++; $display("FAIL midop_total: got %0h expected 0", total_entered); end
        checks++; if (empty !== 2'b11) begin failures++; $display("FAIL midop_empty: got %b expected 11", empty); end
        entry_req = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (entry_grant !== 2'b00) begin failures++; $display("FAIL midop_no_grant: got %b expected 00", entry_grant); end
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL midop_post_occ: got %0h expected 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_same_cycle_full();
        test_bike_empty();
        test_total_sat();
        test_clr_totals();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
